// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART TX scheduler and its arbiter.
// The optional CR LF trailer is enabled by defining UART_SCHED_CRLF_EN.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_STREAM,
        ST_WAIT_DONE
    } sched_state_e;

    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] CRLF_MAX_PAYLOAD = 8'd253;

    // Payload is capped so that payload plus CR LF still fits the 8-bit length.
    function automatic logic [7:0] clamp_payload(input logic [7:0] len);
        return (len > CRLF_MAX_PAYLOAD) ? CRLF_MAX_PAYLOAD : len;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin winner selection: the first asserted request at
// or after rr_ptr, wrapping at N_REQ.
module uart_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [ID_W-1:0]  grant_id,
    output logic             any
);

    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        // NOTE: every output and temporary gets a default first so no path leaves a latch.
        grant_id = '0;
        any      = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!any && req[idx]) begin
                any      = 1'b1;
                grant_id = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing the UART string transceiver TX port between
// N_REQ producers. Define UART_SCHED_CRLF_EN to append CR LF to every string.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_length,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_rd,
    output logic [N_REQ-1:0]   req_done,
    output logic [7:0]         tx_string,
    output logic [7:0]         tx_length,
    output logic               tx_req,
    input  logic               tx_busy,
    input  logic               tx_done,
    input  logic               tx_byte_rd,
    output logic [ID_W-1:0]    grant_id,
    output logic               sched_busy
);

    sched_state_e    state;
    logic [ID_W-1:0] rr_ptr;
    logic [7:0]      cnt;
    logic [7:0]      len_q;
    logic [7:0]      tot_len;
    logic [ID_W-1:0] arb_id;
    logic            arb_any;
    logic [7:0]      raw_len;
    logic [7:0]      win_len;
    logic [7:0]      win_tot;

    uart_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arbiter (
        .req      (req_valid),
        .rr_ptr   (rr_ptr),
        .grant_id (arb_id),
        .any      (arb_any)
    );

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        return {{(N_REQ-1){1'b0}}, 1'b1} << id;
    endfunction

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(N_REQ-1)) ? '0 : id + 1'b1;
    endfunction

    assign raw_len = req_length[8*arb_id +: 8];

`ifdef UART_SCHED_CRLF_EN
    assign win_len = clamp_payload(raw_len);
    assign win_tot = win_len + 8'd2;
    assign tot_len = len_q + 8'd2;
`else
    assign win_len = raw_len;
    assign win_tot = raw_len;
    assign tot_len = len_q;
`endif

    always_comb begin
        tx_string = 8'h00;
        if (state == ST_STREAM) begin
            if (cnt < len_q) begin
                tx_string = req_data[8*grant_id +: 8];
            end else begin
`ifdef UART_SCHED_CRLF_EN
                tx_string = (cnt == len_q) ? ASCII_CR : ASCII_LF;
`else
                tx_string = 8'h00;
`endif
            end
        end
    end

    assign sched_busy = (state != ST_IDLE);

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            cnt       <= '0;
            len_q     <= '0;
            tx_req    <= 1'b0;
            tx_length <= '0;
            req_rd    <= '0;
            req_done  <= '0;
        end else begin
            tx_req   <= 1'b0;
            req_rd   <= '0;
            req_done <= '0;
            case (state)
                ST_IDLE: begin
                    // Skip arbitration while req_done is out: the owner still holds req_valid.
                    if (!tx_busy && arb_any && (req_done == '0)) begin
                        grant_id <= arb_id;
                        len_q    <= win_len;
                        cnt      <= '0;
                        if (win_tot == 8'd0) begin
                            req_done <= onehot(arb_id);
                            rr_ptr   <= next_id(arb_id);
                        end else begin
                            tx_req    <= 1'b1;
                            tx_length <= win_tot;
                            state     <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    tx_length <= '0;
                    state     <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (tx_done) begin
                        req_done <= onehot(grant_id);
                        rr_ptr   <= next_id(grant_id);
                        state    <= ST_IDLE;
                    end else if (tx_byte_rd) begin
                        cnt <= cnt + 8'd1;
                        if (cnt < len_q) begin
                            req_rd <= onehot(grant_id);
                        end
                        if (cnt + 8'd1 == tot_len) begin
                            state <= ST_WAIT_DONE;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        req_done <= onehot(grant_id);
                        rr_ptr   <= next_id(grant_id);
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: table of sequential grants plus
// hand-written busy, zero-length and mid-transfer reset sequences.
module tb_uart_tx_scheduler;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic               sys_clk = 1'b0;
    logic               sys_rst_n;
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_length;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_rd;
    logic [N_REQ-1:0]   req_done;
    logic [7:0]         tx_string;
    logic [7:0]         tx_length;
    logic               tx_req;
    logic               tx_busy;
    logic               tx_done;
    logic               tx_byte_rd;
    logic [ID_W-1:0]    grant_id;
    logic               sched_busy;

    int errors = 0;
    int checks = 0;
    int rd_total  [N_REQ];
    int start_cnt [N_REQ];

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] lens;
        int          exp_id;
        int          abort_at;
    } vec_t;

    vec_t tbl [15];

    uart_tx_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .req_valid  (req_valid),
        .req_length (req_length),
        .req_data   (req_data),
        .req_rd     (req_rd),
        .req_done   (req_done),
        .tx_string  (tx_string),
        .tx_length  (tx_length),
        .tx_req     (tx_req),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_byte_rd (tx_byte_rd),
        .grant_id   (grant_id),
        .sched_busy (sched_busy)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] req_byte(input int i, input int k);
        return 8'(32'h41 + k + 8 * i);
    endfunction

    function automatic int exp_pay(input int len);
`ifdef UART_SCHED_CRLF_EN
        return (len > 253) ? 253 : len;
`else
        return len;
`endif
    endfunction

    function automatic int exp_tot(input int len);
`ifdef UART_SCHED_CRLF_EN
        return exp_pay(len) + 2;
`else
        return len;
`endif
    endfunction

    function automatic logic [7:0] exp_byte(input int id, input int k, input int pay);
        if (k < pay) return req_byte(id, k);
        return (k == pay) ? 8'h0D : 8'h0A;
    endfunction

    // Producer model: each requester's current byte follows its consumed count.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_data[8*i +: 8] = req_byte(i, rd_total[i] - start_cnt[i]);
        end
    end

    always @(posedge sys_clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (req_rd[i]) rd_total[i] <= rd_total[i] + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n && (|req_rd || |req_done)) begin
            check("pulse_exclusive",
                  32'((($onehot(req_rd) && req_done == '0) || ($onehot(req_done) && req_rd == '0))), 32'd1);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic snapshot();
        for (int i = 0; i < N_REQ; i++) start_cnt[i] = rd_total[i];
    endtask

    task automatic wait_req(input string name, output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!tx_req && lat < 20);
        if (!tx_req) begin
            check($sformatf("%s_tx_req_timeout", name), 32'd0, 32'd1);
            lat = 0;
        end
    endtask

    task automatic run_transfer(input string name, input int id, input int len,
                                input int abort_at, input int exp_lat);
        int lat;
        int pay;
        int tot;
        int nbytes;
        logic [3:0] oh;
        pay    = exp_pay(len);
        tot    = exp_tot(len);
        nbytes = (abort_at >= 0) ? abort_at : tot;
        oh     = 4'(1 << id);
        wait_req(name, lat);
        if (lat == 0) return;
        if (exp_lat > 0) check($sformatf("%s_latency", name), 32'(lat), 32'(exp_lat));
        check($sformatf("%s_grant", name), 32'(grant_id), 32'(id));
        check($sformatf("%s_tx_length", name), 32'(tx_length), 32'(tot));
        step();
        check($sformatf("%s_tx_req_pulse", name), 32'(tx_req), 32'd0);
        check($sformatf("%s_busy", name), 32'(sched_busy), 32'd1);
        for (int k = 0; k < nbytes; k++) begin
            check($sformatf("%s_byte%0d", name, k), 32'(tx_string), 32'(exp_byte(id, k, pay)));
            tx_byte_rd = 1'b1;
            step();
            tx_byte_rd = 1'b0;
            check($sformatf("%s_rd%0d", name, k), 32'(req_rd), (k < pay) ? 32'(oh) : 32'd0);
            step();
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check($sformatf("%s_done", name), 32'(req_done), 32'(oh));
        check($sformatf("%s_rd_count", name), 32'(rd_total[id] - start_cnt[id]),
              32'((nbytes < pay) ? nbytes : pay));
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        sys_rst_n  = 1'b0;
        req_valid  = '0;
        req_length = '0;
        tx_busy    = 1'b0;
        tx_done    = 1'b0;
        tx_byte_rd = 1'b0;
        step(2);
        check("rst_tx_req", 32'(tx_req), 32'd0);
        check("rst_tx_length", 32'(tx_length), 32'd0);
        check("rst_tx_string", 32'(tx_string), 32'd0);
        check("rst_req_rd", 32'(req_rd), 32'd0);
        check("rst_req_done", 32'(req_done), 32'd0);
        check("rst_sched_busy", 32'(sched_busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);

        // Lens packed {len3, len2, len1, len0}; grants follow the running rr_ptr.
        tbl[0]  = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd3},   0, -1};
        tbl[1]  = '{4'b0010, {8'd0, 8'd0, 8'd1, 8'd0},   1, -1};
        tbl[2]  = '{4'b1010, {8'd1, 8'd0, 8'd2, 8'd0},   3, -1};
        tbl[3]  = '{4'b0010, {8'd1, 8'd0, 8'd2, 8'd0},   1, -1};
        tbl[4]  = '{4'b1000, {8'd2, 8'd0, 8'd0, 8'd0},   3, -1};
        tbl[5]  = '{4'b1111, {8'd1, 8'd1, 8'd1, 8'd1},   0, -1};
        tbl[6]  = '{4'b1111, {8'd1, 8'd1, 8'd1, 8'd1},   1, -1};
        tbl[7]  = '{4'b1111, {8'd1, 8'd1, 8'd1, 8'd1},   2, -1};
        tbl[8]  = '{4'b1111, {8'd1, 8'd1, 8'd1, 8'd1},   3, -1};
        tbl[9]  = '{4'b1111, {8'd1, 8'd1, 8'd1, 8'd1},   0, -1};
        tbl[10] = '{4'b0100, {8'd0, 8'd3, 8'd0, 8'd0},   2, -1};
        tbl[11] = '{4'b0100, {8'd0, 8'd3, 8'd0, 8'd0},   2, -1};
        tbl[12] = '{4'b0011, {8'd0, 8'd0, 8'd2, 8'd10},  0,  2};
        tbl[13] = '{4'b0010, {8'd0, 8'd0, 8'd2, 8'd10},  1, -1};
        tbl[14] = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd254}, 0, -1};

        sys_rst_n = 1'b1;
        for (int r = 0; r < 15; r++) begin
            req_length = tbl[r].lens;
            req_valid  = tbl[r].valid;
            snapshot();
            run_transfer($sformatf("vec%0d", r), tbl[r].exp_id,
                         int'(tbl[r].lens[8*tbl[r].exp_id +: 8]), tbl[r].abort_at,
                         (r == 0) ? 1 : 2);
            req_valid[tbl[r].exp_id] = 1'b0;
        end

        // Stray tx_byte_rd while idle must not produce a req_rd.
        req_valid  = '0;
        tx_byte_rd = 1'b1;
        step();
        tx_byte_rd = 1'b0;
        check("idle_byte_rd_ignored", 32'(req_rd), 32'd0);
        step();

        // Transceiver busy holds off arbitration.
        tx_busy    = 1'b1;
        req_length = 32'h0000_0001;
        req_valid  = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("busy_hold_tx_req%0d", c), 32'(tx_req), 32'd0);
            check($sformatf("busy_hold_state%0d", c), 32'(sched_busy), 32'd0);
        end
        tx_busy = 1'b0;
        snapshot();
        run_transfer("after_busy", 0, 1, -1, 1);
        req_valid = '0;
        step(2);

        // Zero-length request on requester 2 (rr_ptr now 1).
        req_length = 32'h0000_0000;
        req_valid  = 4'b0100;
        snapshot();
`ifdef UART_SCHED_CRLF_EN
        run_transfer("zero_len", 2, 0, -1, 1);
        req_valid = '0;
`else
        step();
        check("zero_len_done", 32'(req_done), 32'h4);
        check("zero_len_no_tx_req", 32'(tx_req), 32'd0);
        check("zero_len_idle", 32'(sched_busy), 32'd0);
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("zero_len_quiet%0d", c), 32'(tx_req), 32'd0);
        end
`endif

        // Reset in the middle of STREAM; rr_ptr is 3 so requester 1 wins.
        req_length = 32'h0000_0400;
        req_valid  = 4'b0010;
        snapshot();
        wait_req("pre_reset", lat);
        check("pre_reset_grant", 32'(grant_id), 32'd1);
        step();
        tx_byte_rd = 1'b1;
        step();
        tx_byte_rd = 1'b0;
        check("pre_reset_rd", 32'(req_rd), 32'h2);
        step();
        req_valid = 4'b0001;
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_tx_string", 32'(tx_string), 32'd0);
        check("mid_rst_sched_busy", 32'(sched_busy), 32'd0);
        check("mid_rst_grant_id", 32'(grant_id), 32'd0);
        check("mid_rst_req_rd", 32'(req_rd), 32'd0);
        check("mid_rst_tx_req", 32'(tx_req), 32'd0);
        step(2);
        check("mid_rst_no_done", 32'(req_done), 32'd0);
        req_valid  = 4'b0110;
        req_length = 32'h0003_0400;
        sys_rst_n  = 1'b1;
        snapshot();
        run_transfer("post_reset", 1, 4, -1, 1);
        req_valid = '0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
